fifo_drain_arbiter: RTL and testbench

FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

---
 rtl/fifo_arbiter_pkg.sv | 13 +
 rtl/fifo_drain_arbiter_if.sv | 27 ++
 rtl/fifo_drain_arbiter_rr_select.sv | 26 ++
 rtl/fifo_drain_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_drain_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arbiter_pkg.sv
// Shared types and constants for the FIFO drain arbiter.
// Imported by the arbiter top and its sub-modules.
package fifo_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // A configured burst length of zero still drains one word.
  localparam int unsigned BURST_ZERO_LEN = 1;

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// Output word stream of the FIFO drain arbiter.
// The arbiter drives it through master, the consumer through slave.
interface fifo_drain_arbiter_if #(
  parameter int DATA_WIDTH_P = 32,
  parameter int ID_WIDTH_P   = 2
);

  logic                    mst_valid;
  logic                    mst_ready;
  logic [DATA_WIDTH_P-1:0] mst_data;
  logic [ID_WIDTH_P-1:0]   mst_id;

  modport master (
    output mst_valid,
    output mst_data,
    output mst_id,
    input  mst_ready
  );

  modport slave (
    input  mst_valid,
    input  mst_data,
    input  mst_id,
    output mst_ready
  );

endinterface

// File: rtl/fifo_drain_arbiter_rr_select.sv
// Round-robin search: first requester strictly after last_i.
// Purely combinational.
module rr_select #(
  parameter int N_P = 4
) (
  input  logic [N_P-1:0]         req_i,
  input  logic [$clog2(N_P)-1:0] last_i,
  output logic [$clog2(N_P)-1:0] idx_o,
  output logic                   vld_o
);

  localparam int IW = $clog2(N_P);

  // Walk from the farthest offset to the nearest so the last hit wins.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = N_P; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % N_P]) begin
        idx_o = IW'((int'(last_i) + k) % N_P);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains several FWFT FIFOs into one valid/ready stream,
// round-robin, with a bounded burst per grant.
module fifo_drain_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int NR_OF_FIFOS_P = 4,
  parameter int DATA_WIDTH_P  = 32,
  parameter int BURST_WIDTH_P = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic [NR_OF_FIFOS_P-1:0]              fifo_egr_enable,
  input  logic [NR_OF_FIFOS_P*DATA_WIDTH_P-1:0] fifo_egr_data,
  input  logic [NR_OF_FIFOS_P-1:0]              fifo_egr_empty,
  fifo_drain_arbiter_if.master                  mst,
  input  logic [NR_OF_FIFOS_P-1:0]              cr_fifo_mask,
  input  logic [BURST_WIDTH_P-1:0]              cr_burst_length,
  output logic                                  sr_busy,
  output logic [$clog2(NR_OF_FIFOS_P)-1:0]      sr_grant_id
);

  localparam int IdW  = $clog2(NR_OF_FIFOS_P);
  localparam int CntW = BURST_WIDTH_P + 1;

  state_t                  state_q;
  logic [IdW-1:0]          grant_q;
  logic [CntW-1:0]         len_q;
  logic [CntW-1:0]         len_d;
  logic [CntW-1:0]         cnt_q;
  logic [CntW-1:0]         cnt_d;
  logic                    valid_q;
  logic [DATA_WIDTH_P-1:0] data_q;
  logic [IdW-1:0]          id_q;

  logic [NR_OF_FIFOS_P-1:0] req;
  logic [IdW-1:0]           nxt;
  logic                     nxt_vld;
  logic                     pop;

  assign req = ~fifo_egr_empty & cr_fifo_mask;

  rr_select #(
    .N_P (NR_OF_FIFOS_P)
  ) u_rr (
    .req_i  (req),
    .last_i (grant_q),
    .idx_o  (nxt),
    .vld_o  (nxt_vld)
  );

  // Pop only into a free or draining output slot, never during reset.
  assign pop = ~rst
             & (state_q == BURST)
             & ~fifo_egr_empty[grant_q]
             & (~valid_q | mst.mst_ready);

  always_comb begin
    fifo_egr_enable          = '0;
    fifo_egr_enable[grant_q] = pop;
  end

  assign cnt_d = cnt_q + CntW'(1);
  assign len_d = (cr_burst_length == '0)
               ? CntW'(BURST_ZERO_LEN)
               : {1'b0, cr_burst_length};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= IdW'(NR_OF_FIFOS_P - 1);
      len_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      if (pop) begin
        valid_q <= 1'b1;
        data_q  <= fifo_egr_data[grant_q*DATA_WIDTH_P +: DATA_WIDTH_P];
        id_q    <= grant_q;
      end else if (mst.mst_ready) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (nxt_vld) begin
            grant_q <= nxt;
            len_q   <= len_d;
            cnt_q   <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (fifo_egr_empty[grant_q]) begin
            state_q <= IDLE;
          end else if (pop) begin
            cnt_q <= cnt_d;
            if (cnt_d == len_q) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mst.mst_valid = valid_q;
  assign mst.mst_data  = data_q;
  assign mst.mst_id    = id_q;
  assign sr_busy       = (state_q == BURST);
  assign sr_grant_id   = grant_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter with four FWFT FIFO models
// and a consumer that logs every accepted word.
module tb_fifo_drain_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   en;
  logic [3:0]   empty;
  logic [127:0] fdata;
  logic [3:0]   mask;
  logic [7:0]   blen;
  logic         busy;
  logic [1:0]   gid;

  fifo_drain_arbiter_if #(.DATA_WIDTH_P(32), .ID_WIDTH_P(2)) mif ();

  fifo_drain_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_egr_enable (en),
    .fifo_egr_data   (fdata),
    .fifo_egr_empty  (empty),
    .mst             (mif),
    .cr_fifo_mask    (mask),
    .cr_burst_length (blen),
    .sr_busy         (busy),
    .sr_grant_id     (gid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [4][16];
  int          hd   [4] = '{default: 0};
  int          tl   [4] = '{default: 0};
  int          pops [4] = '{default: 0};

  logic [1:0]  log_id   [64];
  logic [31:0] log_data [64];
  int          n_log = 0;

  logic        stall_q = 1'b0;
  logic [31:0] sdata_q = '0;
  logic [1:0]  sid_q   = '0;

  int ids037 [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
  int seq037 [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 2, 2, 2};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] w(input int f, input int s);
    return {f[7:0], s[23:0]};
  endfunction

  task automatic load(input int f, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      mem[f][tl[f] % 16] = w(f, base + k);
      tl[f]++;
    end
  endtask

  task automatic chk_word(input int idx, input int f, input int s);
    chk($sformatf("word%0d_id", idx), 32'(log_id[idx]), 32'(f));
    chk($sformatf("word%0d_data", idx), log_data[idx], w(f, s));
  endtask

  task automatic wait_words(input int n);
    int c = 0;
    while (n_log < n && c < 200) begin
      @(posedge clk);
      c++;
    end
    chk("wait_words", 32'(n_log), 32'(n));
    #1;
  endtask

  task automatic settle_idle(input string tag);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pop"}, 32'(en), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // FIFO models: first-word-fall-through heads, popped on enable.
  always_comb begin
    empty = '0;
    fdata = '0;
    for (int i = 0; i < 4; i++) begin
      empty[i]          = (hd[i] == tl[i]);
      fdata[i*32 +: 32] = mem[i][hd[i] % 16];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        hd[i]   <= hd[i] + 1;
        pops[i] <= pops[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (en[i]) chk("pop_on_empty", 32'(empty[i]), 32'd0);
    end
    if (en != 4'd0) begin
      chk("pop_while_stalled",
          32'(mif.mst_valid & ~mif.mst_ready), 32'd0);
    end
    if (stall_q && mif.mst_valid && !rst) begin
      chk("stall_data", mif.mst_data, sdata_q);
      chk("stall_id", 32'(mif.mst_id), 32'(sid_q));
    end
    stall_q <= mif.mst_valid & ~mif.mst_ready & ~rst;
    sdata_q <= mif.mst_data;
    sid_q   <= mif.mst_id;
    if (!rst && mif.mst_valid && mif.mst_ready && n_log < 64) begin
      log_id[n_log]   <= mif.mst_id;
      log_data[n_log] <= mif.mst_data;
      n_log           <= n_log + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p1;
    int c;
    mask          = 4'hf;
    blen          = 8'd2;
    mif.mst_ready = 1'b1;
    rst           = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(mif.mst_valid), 32'd0);
    chk("rst_data", mif.mst_data, 32'd0);
    chk("rst_id", 32'(mif.mst_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(gid), 32'd3);
    chk("rst_pop", 32'(en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Four FIFOs of three words, bursts of two.
    for (int f = 0; f < 4; f++) load(f, 3, 0);
    wait_words(12);
    for (int k = 0; k < 12; k++) chk_word(k, ids037[k], seq037[k]);
    settle_idle("rr");
    chk("rr_drained", 32'(empty), 32'hf);
    chk("rr_grant", 32'(gid), 32'd3);

    // Single FIFO shorter than the burst; mask cleared mid-burst.
    blen = 8'd8;
    load(2, 5, 0);
    wait_words(13);
    mask = 4'h0;
    wait_words(17);
    for (int k = 0; k < 5; k++) chk_word(12 + k, 2, k);
    settle_idle("early");
    chk("early_grant", 32'(gid), 32'd2);
    chk("early_drained", 32'(empty), 32'hf);
    mask = 4'hf;

    // Consumer ready toggling every cycle.
    load(1, 4, 0);
    c = 0;
    while (n_log < 21 && c < 100) begin
      @(posedge clk);
      #1 mif.mst_ready = ~mif.mst_ready;
      c++;
    end
    mif.mst_ready = 1'b1;
    wait_words(21);
    for (int k = 0; k < 4; k++) chk_word(17 + k, 1, k);
    settle_idle("toggle");

    // Mask 1010: grants alternate between FIFO 1 and 3.
    mask = 4'b1010;
    blen = 8'd1;
    load(0, 2, 3);
    load(1, 2, 4);
    load(2, 2, 5);
    load(3, 2, 3);
    wait_words(25);
    chk_word(21, 3, 3);
    chk_word(22, 1, 4);
    chk_word(23, 3, 4);
    chk_word(24, 1, 5);
    settle_idle("mask");
    chk("mask_left", 32'(empty), 32'b1010);

    // Zero burst length: one word per grant.
    mask = 4'b0101;
    blen = 8'd0;
    wait_words(29);
    chk_word(25, 2, 5);
    chk_word(26, 0, 3);
    chk_word(27, 2, 6);
    chk_word(28, 0, 4);
    settle_idle("zero");
    chk("zero_drained", 32'(empty), 32'hf);

    // Reset during the third word of a burst.
    mask = 4'hf;
    blen = 8'd8;
    load(0, 1, 10);
    load(1, 6, 10);
    p1 = pops[1];
    c  = 0;
    while (pops[1] - p1 < 3 && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("rst_trigger", 32'(pops[1] - p1), 32'd3);
    rst           = 1'b1;
    mif.mst_ready = 1'b0;
    @(negedge clk);
    chk("midrst_pop", 32'(en), 32'd0);
    chk("midrst_hold", mif.mst_data, w(1, 12));
    @(posedge clk);
    #1;
    rst           = 1'b0;
    mif.mst_ready = 1'b1;
    @(negedge clk);
    chk("postrst_valid", 32'(mif.mst_valid), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_grant", 32'(gid), 32'd3);
    chk("postrst_pops", 32'(pops[1] - p1), 32'd3);
    chk("postrst_fill", 32'(tl[1] - hd[1]), 32'd3);
    chk_word(29, 1, 10);
    chk_word(30, 1, 11);
    wait_words(35);
    chk_word(31, 0, 10);
    chk_word(32, 1, 13);
    chk_word(33, 1, 14);
    chk_word(34, 1, 15);
    settle_idle("end");
    chk("end_drained", 32'(empty), 32'hf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
